program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Upstream of the single-cycle MIPS core. Streams a program image into instruction memory over a valid/ready word interface.
- Holds the core in reset while loading. Releases it once the last word is written and a guard interval has elapsed.
- Sits between the host/testbench word source and the instruction memory write port plus the core's active-high reset input.

Parameters:
- ADDR_WIDTH, 8, instruction memory word-address width; depth = 2**ADDR_WIDTH words.
- RELEASE_CYCLES, 2, cycles core_reset stays high after the final write completes (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a new load.
- in_valid  input  1  source has a word on in_data.
- in_data  input  32  instruction word.
- in_last  input  1  qualifies in_data as the final word of the image.
- in_ready  output  1  loader accepts a word this cycle.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  ADDR_WIDTH  word address (byte address = imem_addr<<2).
- imem_wdata  output  32  write data.
- core_reset  output  1  active-high reset to the core.
- done  output  1  image loaded, core running.
- error  output  1  image overflowed memory.
- word_count  output  ADDR_WIDTH+1  words accepted in the current load.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, done=0, error=0, word_count=0, release counter=0.
- States: IDLE, LOAD, RELEASE, RUN, ERROR.
- IDLE: core_reset=1. start -> LOAD; word_count and write pointer clear to 0.
- LOAD: in_ready=1. A word is accepted when in_valid and in_ready are both high in the same cycle.
  - Write latency: accept in cycle N -> imem_we=1 in cycle N+1 with registered imem_addr = pointer and imem_wdata = in_data.
  - imem_we is a single-cycle pulse per accepted word. Pointer and word_count increment on accept.
  - Accepted word with in_last=1 -> RELEASE.
  - Accepted word at pointer = DEPTH-1 with in_last=0 -> ERROR. That word is still written.
  - in_valid=0: no write, state holds, no timeout.
- RELEASE: in_ready=0, core_reset=1. The counter runs RELEASE_CYCLES cycles starting the cycle after the final imem_we. Expiry -> RUN.
- RUN: core_reset=0, done=1, in_ready=0. The core fetches from address 0.
- ERROR: error=1 (sticky until reset or start), core_reset=1, in_ready=0, done=0.
- start in any state other than IDLE aborts the current activity:
  - next cycle: state=LOAD, core_reset=1, done=0, error=0, word_count=0, pointer=0.
  - a pending (already accepted) write still completes.
  - start takes priority over a simultaneous accept; that word is dropped.
- Words offered outside LOAD are ignored (in_ready=0).
- word_count is ADDR_WIDTH+1 bits wide, so a full image reads exactly DEPTH with no wrap.
- Mid-operation async reset: all outputs return to reset values immediately. Memory contents are undefined and must be reloaded.
- All outputs are registered; no combinational path from inputs to outputs except none.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=0, LOAD=1, RELEASE=2, RUN=3, ERROR=4, 3 bits);
  - the word width constant (32);
  - a shared instruction-memory address width constant so InstructionMemory and this block agree.
- One natural sub-module: loader_write_stage. It holds the registered imem_we/imem_addr/imem_wdata pipeline register with its own async active-low reset.
- The FSM, counters and handshake stay in the top.

Test Plan:
- Reset then start, 4 words 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000 with in_last on the 4th:
  - imem_we pulses at addresses 0..3 one cycle after each accept;
  - core_reset falls exactly 2 cycles after the last write; done=1; word_count=4.
- Source stalls (in_valid low 3 cycles between words 1 and 2) -> no spurious imem_we; addresses remain contiguous 0,1.
- ADDR_WIDTH=2, stream 4 words with in_last=0 -> all 4 written at 0..3; error=1, in_ready=0, core_reset=1, word_count=4. A 5th offered word is never accepted.
- In RUN, pulse start -> next cycle core_reset=1, done=0, word_count=0. Reload of 2 words writes addresses 0,1.
- Assert reset low mid-LOAD after 2 accepts -> immediately in_ready=0, imem_we=0, core_reset=1, word_count=0, state IDLE.
- start coincident with an accepted word in LOAD -> that word is not written; pointer restarts at 0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and the instruction memory it feeds.
package program_loader_pkg;

    localparam int WORD_W      = 32;
    localparam int IMEM_ADDR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Word-stream, memory-write and core-control signals between host and loader.
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_W
) ();

    logic                  start;
    logic                  in_valid;
    logic [WORD_W-1:0]     in_data;
    logic                  in_last;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [WORD_W-1:0]     imem_wdata;
    logic                  core_reset;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH:0]   word_count;

    modport master (
        output start, in_valid, in_data, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata,
        input  core_reset, done, error, word_count
    );

    modport slave (
        input  start, in_valid, in_data, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata,
        output core_reset, done, error, word_count
    );

endinterface

// File: rtl/loader_write_stage.sv
// Registers each accepted word into a one-cycle instruction-memory write.
module loader_write_stage
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_capture,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [WORD_W-1:0]     i_data,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [WORD_W-1:0]     o_data
);

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WORD_W-1:0]     r_data;

    // Address and data hold between writes; only the enable pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= i_capture;
            if (i_capture) begin
                r_addr <= i_addr;
                r_data <= i_data;
            end
        end
    end

    assign o_we   = r_we;
    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule

// File: rtl/program_loader.sv
// Streams a program image into instruction memory and holds the core in reset
// until the image is complete and a guard interval has elapsed.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = IMEM_ADDR_W,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;
    localparam logic [3:0]            REL_LAST = 4'(RELEASE_CYCLES - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [3:0]            r_rel_cnt;
    logic                  r_in_ready;
    logic                  r_core_reset;
    logic                  r_done;
    logic                  r_error;

    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] w_next_ptr;
    logic [ADDR_WIDTH:0]   w_next_count;
    logic [3:0]            w_next_rel;
    logic                  w_accept;

    // start overrides everything, including a word handshaking in the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        w_next_count = r_count;
        w_next_rel   = '0;
        w_accept     = 1'b0;
        if (bus.start) begin
            w_next_state = ST_LOAD;
            w_next_ptr   = '0;
            w_next_count = '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (bus.in_valid && r_in_ready) begin
                        w_accept     = 1'b1;
                        w_next_ptr   = r_ptr + 1'b1;
                        w_next_count = r_count + 1'b1;
                        if (bus.in_last)
                            w_next_state = ST_RELEASE;
                        else if (r_ptr == LAST_PTR)
                            w_next_state = ST_ERROR;
                    end
                end
                ST_RELEASE: begin
                    if (r_rel_cnt == REL_LAST)
                        w_next_state = ST_RUN;
                    else
                        w_next_rel = r_rel_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_count      <= '0;
            r_rel_cnt    <= '0;
            r_in_ready   <= 1'b0;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_ptr        <= w_next_ptr;
            r_count      <= w_next_count;
            r_rel_cnt    <= w_next_rel;
            r_in_ready   <= (w_next_state == ST_LOAD);
            r_core_reset <= (w_next_state != ST_RUN);
            r_done       <= (w_next_state == ST_RUN);
            r_error      <= (w_next_state == ST_ERROR);
        end
    end

    loader_write_stage #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_write_stage (
        .clk       (clk),
        .reset     (reset),
        .i_capture (w_accept),
        .i_addr    (r_ptr),
        .i_data    (bus.in_data),
        .o_we      (bus.imem_we),
        .o_addr    (bus.imem_addr),
        .o_data    (bus.imem_wdata)
    );

    assign bus.in_ready   = r_in_ready;
    assign bus.core_reset = r_core_reset;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign bus.word_count = r_count;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: an 8-bit-address instance for the main
// load/abort/reset cases and a 2-bit-address instance for the overflow case.
module tb_program_loader;
  import program_loader_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_WIDTH(8)) la ();
  program_loader_if #(.ADDR_WIDTH(2)) lb ();

  program_loader #(.ADDR_WIDTH(8), .RELEASE_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .bus(la.slave));
  program_loader #(.ADDR_WIDTH(2), .RELEASE_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .bus(lb.slave));

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0]  wa_addr[$];
  logic [31:0] wa_data[$];
  int          wa_cyc[$];
  logic [1:0]  wb_addr[$];
  logic [31:0] wb_data[$];
  int          fall_cyc = -1;
  logic        prev_cr = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (la.imem_we === 1'b1) begin
      wa_addr.push_back(la.imem_addr);
      wa_data.push_back(la.imem_wdata);
      wa_cyc.push_back(cyc);
    end
    if (lb.imem_we === 1'b1) begin
      wb_addr.push_back(lb.imem_addr);
      wb_data.push_back(lb.imem_wdata);
    end
    if (prev_cr === 1'b1 && la.core_reset === 1'b0) fall_cyc = cyc;
    prev_cr = la.core_reset;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic s, input logic v, input logic [31:0] data, input logic l);
    if (d == 0) begin
      la.start = s; la.in_valid = v; la.in_data = data; la.in_last = l;
    end else begin
      lb.start = s; lb.in_valid = v; lb.in_data = data; lb.in_last = l;
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? la.in_ready : lb.in_ready;
  endfunction

  task automatic pulse_start(input int d);
    drive(d, 1'b1, 1'b0, 32'h0, 1'b0);
    tick(1);
    drive(d, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic send_word(input int d, input logic [31:0] data, input logic last);
    logic acc;
    logic got_it;
    got_it = 1'b0;
    drive(d, 1'b0, 1'b1, data, last);
    for (int i = 0; i < 20; i++) begin
      if (!got_it) begin
        acc = rdy(d);
        tick(1);
        if (acc === 1'b1) got_it = 1'b1;
      end
    end
    if (!got_it) check_val("send_timeout", 64'd0, 64'd1);
    drive(d, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic clear_logs();
    wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
    wb_addr.delete(); wb_data.delete();
    fall_cyc = -1;
  endtask

  logic [31:0] prog[4];

  initial begin
    prog[0] = 32'h20080005; prog[1] = 32'h20090003;
    prog[2] = 32'h01095020; prog[3] = 32'hAC0A0000;
    drive(0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Reset state
    reset = 1'b0;
    tick(2);
    check_val("rst_in_ready", la.in_ready, 0);
    check_val("rst_imem_we", la.imem_we, 0);
    check_val("rst_imem_addr", la.imem_addr, 0);
    check_val("rst_imem_wdata", la.imem_wdata, 0);
    check_val("rst_core_reset", la.core_reset, 1);
    check_val("rst_done", la.done, 0);
    check_val("rst_error", la.error, 0);
    check_val("rst_word_count", la.word_count, 0);
    reset = 1'b1;
    tick(2);
    check_val("idle_in_ready", la.in_ready, 0);

    // Full 4-word image
    pulse_start(0);
    check_val("load_in_ready", la.in_ready, 1);
    clear_logs();
    for (int i = 0; i < 4; i++) send_word(0, prog[i], (i == 3));
    tick(5);
    check_val("img_nwrites", wa_addr.size(), 4);
    for (int i = 0; i < 4 && i < wa_addr.size(); i++) begin
      check_val($sformatf("img_addr%0d", i), wa_addr[i], i);
      check_val($sformatf("img_data%0d", i), wa_data[i], prog[i]);
    end
    if (wa_cyc.size() == 4) check_val("release_delay", fall_cyc - wa_cyc[3], 2);
    check_val("run_done", la.done, 1);
    check_val("run_core_reset", la.core_reset, 0);
    check_val("run_word_count", la.word_count, 4);
    check_val("run_in_ready", la.in_ready, 0);
    check_val("run_error", la.error, 0);

    // Abort from RUN, then reload with a stalled source
    pulse_start(0);
    check_val("abort_core_reset", la.core_reset, 1);
    check_val("abort_done", la.done, 0);
    check_val("abort_word_count", la.word_count, 0);
    check_val("abort_in_ready", la.in_ready, 1);
    clear_logs();
    send_word(0, 32'hCAFE0001, 1'b0);
    tick(3);
    send_word(0, 32'hCAFE0002, 1'b1);
    tick(5);
    check_val("stall_nwrites", wa_addr.size(), 2);
    if (wa_addr.size() == 2) begin
      check_val("stall_addr0", wa_addr[0], 0);
      check_val("stall_addr1", wa_addr[1], 1);
      check_val("stall_data1", wa_data[1], 32'hCAFE0002);
    end
    check_val("stall_done", la.done, 1);

    // start coincident with an accepted word
    pulse_start(0);
    clear_logs();
    send_word(0, 32'h11111111, 1'b0);
    drive(0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
    tick(1);
    drive(0, 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("coinc_word_count", la.word_count, 0);
    check_val("coinc_in_ready", la.in_ready, 1);
    send_word(0, 32'h22222222, 1'b1);
    tick(5);
    check_val("coinc_nwrites", wa_addr.size(), 2);
    if (wa_addr.size() == 2) begin
      check_val("coinc_data0", wa_data[0], 32'h11111111);
      check_val("coinc_addr1", wa_addr[1], 0);
      check_val("coinc_data1", wa_data[1], 32'h22222222);
    end
    check_val("coinc_word_count_end", la.word_count, 1);

    // Asynchronous reset in the middle of a load
    pulse_start(0);
    send_word(0, 32'h33333333, 1'b0);
    send_word(0, 32'h44444444, 1'b0);
    reset = 1'b0;
    #1;
    check_val("areset_in_ready", la.in_ready, 0);
    check_val("areset_imem_we", la.imem_we, 0);
    check_val("areset_core_reset", la.core_reset, 1);
    check_val("areset_word_count", la.word_count, 0);
    check_val("areset_done", la.done, 0);
    tick(1);
    reset = 1'b1;
    tick(2);
    check_val("areset_idle_in_ready", la.in_ready, 0);

    // Overflow on the 4-word memory
    pulse_start(1);
    clear_logs();
    for (int i = 0; i < 4; i++) send_word(1, 32'hB0 + i, 1'b0);
    tick(2);
    check_val("ovf_nwrites", wb_addr.size(), 4);
    for (int i = 0; i < 4 && i < wb_addr.size(); i++) begin
      check_val($sformatf("ovf_addr%0d", i), wb_addr[i], i);
      check_val($sformatf("ovf_data%0d", i), wb_data[i], 32'hB0 + i);
    end
    check_val("ovf_error", lb.error, 1);
    check_val("ovf_in_ready", lb.in_ready, 0);
    check_val("ovf_core_reset", lb.core_reset, 1);
    check_val("ovf_word_count", lb.word_count, 4);
    check_val("ovf_done", lb.done, 0);
    drive(1, 1'b0, 1'b1, 32'hB4, 1'b0);
    tick(5);
    drive(1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(2);
    check_val("ovf_5th_nwrites", wb_addr.size(), 4);
    check_val("ovf_5th_word_count", lb.word_count, 4);
    check_val("ovf_5th_error", lb.error, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
